// File: rtl/sa_fifo_pkg.sv
// sa_fifo_pkg: shared constants and pointer-wrap helper for the 20x16 FIFO
// controller.
//   DEPTH    : RAM entries (20), fixed to match the RAM macro
//   WIDTH    : payload bits (16)
//   AW       : RAM address width (5)
//   next_ptr : pointer increment with 19 -> 0 wrap
package sa_fifo_pkg;

  localparam int DEPTH = 20;
  localparam int WIDTH = 16;
  localparam int AW    = 5;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

endpackage

// File: rtl/sa_fifo_ptr.sv
// sa_fifo_ptr: wrapping RAM pointer (0..DEPTH-1) with increment enable.
// Ports:
//   clk, reset : clock, async active-high reset (pointer -> 0)
//   inc        : advance pointer this cycle
//   ptr        : current pointer value
module sa_fifo_ptr
  import sa_fifo_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = next_ptr(ptr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sa_fifo_ctrl_20x16.sv
// sa_fifo_ctrl_20x16: valid/ready FIFO controller around an external 20x16
// two-port RAM with registered read (address latch, then output register)
// and an output bypass mux. The RAM data output is the FIFO read data.
// Ports:
//   clk, reset            : clock, async active-high reset
//   wr_pvld/wr_prdy/wr_pd : producer handshake and payload
//   rd_pvld/rd_prdy       : consumer handshake (data = RAM dout)
//   ram_we/ram_wa/ram_di  : RAM write port
//   ram_re/ram_ra         : RAM read-address latch enable / address
//   ram_ore               : RAM output-register enable
//   ram_byp_sel/ram_dbyp  : RAM bypass select / bypass data
//   fifo_cnt              : total entries held (0..21)
// Build option: define SA_FIFO_CTRL_BYPASS_EN to let a write into an
// otherwise empty pipeline go straight to the output register (1-cycle
// latency). Without it every entry goes through the RAM (3-cycle latency).
module sa_fifo_ctrl_20x16
  import sa_fifo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic             ram_re,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_ore,
  output logic             ram_byp_sel,
  output logic [WIDTH-1:0] ram_dbyp,
  output logic [AW-1:0]    fifo_cnt
);

  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH);

  // ram_cnt counts RAM slots not yet moved into the output register,
  // including the one whose address sits in the read latch (s1).
  logic [AW-1:0] ram_cnt_q, ram_cnt_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;

  logic wr_acc, pop, s2_free, ore_ram, s1_free, unread, re, we, byp;
  logic [AW-1:0] wptr, rptr;

  always_comb begin
    wr_acc  = wr_pvld & wr_prdy;
    pop     = s2_vld_q & rd_prdy;
    s2_free = ~s2_vld_q | pop;
    ore_ram = s1_vld_q & s2_free;
    s1_free = ~s1_vld_q | ore_ram;
    // Entries written in earlier cycles that have no read issued yet.
    unread  = ram_cnt_q > {{(AW-1){1'b0}}, s1_vld_q};
    re      = s1_free & unread;
    byp     = 1'b0;
`ifdef SA_FIFO_CTRL_BYPASS_EN
    byp     = wr_acc & (ram_cnt_q == '0) & ~s1_vld_q & s2_free;
`endif
    we      = wr_acc & ~byp;

    s1_vld_d = s1_vld_q;
    if (re)           s1_vld_d = 1'b1;
    else if (ore_ram) s1_vld_d = 1'b0;

    s2_vld_d = s2_vld_q;
    if (ore_ram | byp) s2_vld_d = 1'b1;
    else if (pop)      s2_vld_d = 1'b0;

    ram_cnt_d = ram_cnt_q;
    case ({we, ore_ram})
      2'b10:   ram_cnt_d = ram_cnt_q + AW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - AW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
    end else begin
      ram_cnt_q <= ram_cnt_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
    end
  end

  sa_fifo_ptr u_wptr (.clk(clk), .reset(reset), .inc(we), .ptr(wptr));
  sa_fifo_ptr u_rptr (.clk(clk), .reset(reset), .inc(re), .ptr(rptr));

  // Readiness depends only on registered state: no wr_pvld/rd_prdy path.
  assign wr_prdy     = ram_cnt_q < CNT_MAX;
  assign rd_pvld     = s2_vld_q;
  assign ram_we      = we;
  assign ram_wa      = wptr;
  assign ram_di      = wr_pd;
  assign ram_re      = re;
  assign ram_ra      = rptr;
  assign ram_ore     = ore_ram | byp;
  assign ram_byp_sel = byp;
  assign ram_dbyp    = wr_pd;
  assign fifo_cnt    = ram_cnt_q + {{(AW-1){1'b0}}, s2_vld_q};

endmodule

// File: tb/tb_sa_fifo_ctrl_20x16.sv
// Bench for sa_fifo_ctrl_20x16: behavioural RAM next to the controller plus
// a queue scoreboard of accepted words; random handshake streams.
module tb_sa_fifo_ctrl_20x16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [15:0] wr_pd, ram_di, ram_dbyp;
  logic        ram_we, ram_re, ram_ore, ram_byp_sel;
  logic [4:0]  ram_wa, ram_ra, fifo_cnt;

  int nvec = 0;
  int nerr = 0;

  // RAM model and scoreboard
  logic [15:0] mem [0:31];
  logic [4:0]  ra_d;
  logic [15:0] m_dout;
  logic [15:0] exp_q[$];
  logic [4:0]  exp_wa, exp_ra;

  always #5 clk = ~clk;

  sa_fifo_ctrl_20x16 dut (
    .clk(clk), .reset(reset),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
    .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp), .fifo_cnt(fifo_cnt)
  );

  function automatic logic [4:0] wrap_inc(input logic [4:0] p);
    return (p >= 5'd19) ? 5'd0 : p + 5'd1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      exp_wa <= 5'd0;
      exp_ra <= 5'd0;
    end else begin
      if (rd_pvld && rd_prdy && exp_q.size() > 0) void'(exp_q.pop_front());
      if (wr_pvld && wr_prdy) exp_q.push_back(wr_pd);
      if (ram_we) begin
        mem[ram_wa] <= ram_di;
        exp_wa      <= wrap_inc(exp_wa);
      end
      if (ram_re) begin
        ra_d   <= ram_ra;
        exp_ra <= wrap_inc(exp_ra);
      end
      if (ram_ore) m_dout <= ram_byp_sel ? ram_dbyp : mem[ra_d];
    end
  end

  task automatic test_reset();
    reset = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if ({wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, ram_byp_sel, ram_wa, ram_ra, fifo_cnt} !== {1'b1, 20'd0}) begin
      nerr++;
      $display("FAIL reset_outs: got %b want %b",
        {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, ram_byp_sel, ram_wa, ram_ra, fifo_cnt}, {1'b1, 20'd0});
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    nvec++;
    if (fifo_cnt !== 5'd0 || wr_prdy !== 1'b1) begin
      nerr++;
      $display("FAIL reset_release: cnt %0d prdy %b want 0/1", fifo_cnt, wr_prdy);
    end
  endtask

  task automatic test_single();
    int lat;
    int exp_lat;
    @(negedge clk);
    wr_pvld = 1'b1; wr_pd = 16'hA5A5; rd_prdy = 1'b1;
    #1;
    nvec++;
`ifdef SA_FIFO_CTRL_BYPASS_EN
    exp_lat = 1;
    if (ram_we !== 1'b0 || ram_byp_sel !== 1'b1 || ram_ore !== 1'b1) begin
      nerr++;
      $display("FAIL single_byp_ctl: we %b byp %b ore %b want 0/1/1", ram_we, ram_byp_sel, ram_ore);
    end
`else
    exp_lat = 3;
    if (ram_we !== 1'b1 || ram_byp_sel !== 1'b0 || ram_wa !== 5'd0) begin
      nerr++;
      $display("FAIL single_we: we %b byp %b wa %0d want 1/0/0", ram_we, ram_byp_sel, ram_wa);
    end
`endif
    @(negedge clk);
    wr_pvld = 1'b0;
    lat = 1;
    #1;
    while (!rd_pvld && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    nvec++;
    if (lat !== exp_lat) begin
      nerr++;
      $display("FAIL single_latency: got %0d edges want %0d", lat, exp_lat);
    end
    nvec++;
    if (m_dout !== 16'hA5A5) begin
      nerr++;
      $display("FAIL single_data: got %h want a5a5", m_dout);
    end
    @(negedge clk); rd_prdy = 1'b0;
    #1;
    nvec++;
    if (fifo_cnt !== 5'd0 || rd_pvld !== 1'b0) begin
      nerr++;
      $display("FAIL single_drain: cnt %0d pvld %b want 0/0", fifo_cnt, rd_pvld);
    end
  endtask

  // Generic stream of n words from base; optional random valid/ready.
  // Runs until all words are sent and the FIFO has drained.
  task automatic stream(input int n, input logic [15:0] base, input bit rnd_rd, input bit rnd_wr);
    int sent, got, guard, init;
    sent = 0; got = 0; guard = 0; init = exp_q.size();
    while ((sent < n || exp_q.size() > 0) && guard < 5000) begin
      @(negedge clk);
      wr_pvld = (sent < n) && (!rnd_wr || ($urandom_range(1, 0) == 1));
      wr_pd   = base + 16'(sent);
      rd_prdy = !rnd_rd || ($urandom_range(1, 0) == 1);
      #1;
      if (rd_pvld && rd_prdy) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL stream_spurious: popped %h from empty model", m_dout);
        end else if (m_dout !== exp_q[0]) begin
          nerr++;
          $display("FAIL stream_data: got %h want %h", m_dout, exp_q[0]);
        end
        got++;
      end
      nvec++;
      if (fifo_cnt !== 5'(exp_q.size())) begin
        nerr++;
        $display("FAIL stream_cnt: got %0d want %0d", fifo_cnt, exp_q.size());
      end
      nvec++;
      if (ram_ra !== exp_ra) begin
        nerr++;
        $display("FAIL stream_ra: got %0d want %0d", ram_ra, exp_ra);
      end
      if (ram_we) begin
        nvec++;
        if (ram_wa !== exp_wa) begin
          nerr++;
          $display("FAIL stream_wa: got %0d want %0d", ram_wa, exp_wa);
        end
      end
      if (exp_q.size() <= 19 && wr_prdy !== 1'b1) begin
        nerr++; nvec++;
        $display("FAIL stream_prdy_low: got 0 want 1 at size %0d", exp_q.size());
      end
      if (exp_q.size() >= 21 && wr_prdy !== 1'b0) begin
        nerr++; nvec++;
        $display("FAIL stream_prdy_high: got 1 want 0 at size %0d", exp_q.size());
      end
`ifndef SA_FIFO_CTRL_BYPASS_EN
      if (ram_byp_sel !== 1'b0) begin
        nerr++; nvec++;
        $display("FAIL stream_byp: got 1 want 0");
      end
`endif
      if (wr_pvld && wr_prdy) sent++;
      guard++;
    end
    @(negedge clk);
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    nvec++;
    if (guard >= 5000 || got !== n + init) begin
      nerr++;
      $display("FAIL stream_total: got %0d words want %0d (cycles %0d)", got, n + init, guard);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      wr_pvld = 1'b1; wr_pd = 16'(i); rd_prdy = 1'b0;
      #1;
      nvec++;
      if (wr_prdy !== 1'b1) begin
        nerr++;
        $display("FAIL fill_prdy: word %0d got 0 want 1", i);
      end
    end
    @(negedge clk);
    wr_pvld = 1'b0;
    #1;
    nvec++;
    if (wr_prdy !== 1'b0 || fifo_cnt !== 5'd21 || rd_pvld !== 1'b1 || m_dout !== 16'd0) begin
      nerr++;
      $display("FAIL fill_full: prdy %b cnt %0d pvld %b dout %h want 0/21/1/0000",
               wr_prdy, fifo_cnt, rd_pvld, m_dout);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_pvld = 1'b1; wr_pd = 16'h0099;
      #1;
      nvec++;
      if (wr_prdy !== 1'b0 || fifo_cnt !== 5'd21) begin
        nerr++;
        $display("FAIL fill_stall: prdy %b cnt %0d want 0/21", wr_prdy, fifo_cnt);
      end
    end
  endtask

  task automatic test_full_simul();
    @(negedge clk);
    wr_pvld = 1'b1; wr_pd = 16'd21; rd_prdy = 1'b1;
    #1;
    nvec++;
    if (wr_prdy !== 1'b0 || m_dout !== 16'd0) begin
      nerr++;
      $display("FAIL full_same_cycle: prdy %b dout %h want 0/0000", wr_prdy, m_dout);
    end
    @(negedge clk);
    rd_prdy = 1'b0;
    #1;
    nvec++;
    if (wr_prdy !== 1'b1 || fifo_cnt !== 5'd20) begin
      nerr++;
      $display("FAIL full_next: prdy %b cnt %0d want 1/20", wr_prdy, fifo_cnt);
    end
    @(negedge clk);
    wr_pvld = 1'b0;
    #1;
    nvec++;
    if (fifo_cnt !== 5'd21 || wr_prdy !== 1'b0) begin
      nerr++;
      $display("FAIL full_after: cnt %0d prdy %b want 21/0", fifo_cnt, wr_prdy);
    end
    stream(0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_pvld = 1'b1; wr_pd = 16'h3000 + 16'(i); rd_prdy = 1'b0;
    end
    @(negedge clk);
    wr_pvld = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    nvec++;
    if ({wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, ram_byp_sel, ram_wa, ram_ra, fifo_cnt} !== {1'b1, 20'd0}) begin
      nerr++;
      $display("FAIL reset_mid: got %b want %b",
        {wr_prdy, rd_pvld, ram_we, ram_re, ram_ore, ram_byp_sel, ram_wa, ram_ra, fifo_cnt}, {1'b1, 20'd0});
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk); #1;
    nvec++;
    if (fifo_cnt !== 5'd0 || rd_pvld !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid_release: cnt %0d pvld %b want 0/0", fifo_cnt, rd_pvld);
    end
    stream(30, 16'h4000, 1'b1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    stream(50, 16'h1000, 1'b0, 1'b0);   // wrap: pointers pass 19 -> 0 twice
    stream(100, 16'h2000, 1'b1, 1'b0);  // stall: random consumer ready
    stream(100, 16'h5000, 1'b1, 1'b1);  // random both sides
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
